id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end for the 5-stage MIPS32 core.
- Captures decoded control and register-file operands at the end of ID. Resolves forwarding from EX/MEM/load data at the ID side.
- Drives the registered operand pair and ALU control straight into the EX-stage ALU, plus the control bundle for EX/MEM.
- Owns bubble insertion (stall) and squash (flush) for the EX stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RA_IDX, 31, destination register forced for jal.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  load-use hazard; insert bubble into EX.
- flush  in  1  squash the instruction entering EX (branch/jump redirect).
- d_valid  in  1  ID holds a real instruction.
- d_wreg  in  1  ID regfile write enable.
- d_m2reg  in  1  ID: writeback selects memory data.
- d_wmem  in  1  ID memory write enable.
- d_jal  in  1  ID instruction is jal.
- d_aluimm  in  1  ALU operand b = immediate.
- d_shift  in  1  ALU operand a = shamt.
- d_aluc  in  4  ALU opcode, passed through unchanged.
- d_rn  in  5  destination register number.
- d_pc4  in  32  PC+4 of ID instruction.
- d_qa  in  32  regfile rs data.
- d_qb  in  32  regfile rt data.
- d_imm  in  32  extended immediate; shamt is d_imm[10:6].
- d_fwda  in  2  rs source select: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data.
- d_fwdb  in  2  rt source select, same encoding.
- x_alu  in  32  current EX ALU result (ALU r).
- m_alu  in  32  MEM-stage ALU result.
- m_mdo  in  32  MEM-stage load data.
- e_valid  out  1  EX holds a real instruction.
- e_wreg  out  1  registered control.
- e_m2reg  out  1  registered control.
- e_wmem  out  1  registered control.
- e_jal  out  1  registered control.
- e_aluc  out  4  to ALU aluc.
- e_rn  out  5  destination register; RA_IDX when jal.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- e_sdata  out  32  forwarded rt, for store data.
- e_pc8  out  32  link value, registered d_pc4 + 4.

Behaviour:
- Reset (rst=1, asynchronous): every output and internal register is 0. This includes e_aluc=0 (add), so a reset bubble computes 0+0 and writes nothing.
- Forwarding is combinational on d_fwda/d_fwdb and selects fa, fb from {d_qa | x_alu | m_alu | m_mdo}. No priority logic lives here; the hazard unit guarantees the selects.
- Operand select happens before the register:
  - a_nxt = d_shift ? {27'b0, d_imm[10:6]} : fa.
  - b_nxt = d_aluimm ? d_imm : fb.
  - sdata_nxt = fb, always the forwarded rt, independent of d_aluimm.
- Latency: one cycle. The values present in ID at edge N appear on alu_a/alu_b/e_* after edge N. No internal enable; the stage always advances.
- Bubble rule: if stall|flush|~d_valid at the edge:
  - e_valid, e_wreg, e_wmem, e_m2reg, e_jal all load 0.
  - e_aluc, alu_a, alu_b, e_sdata, e_rn, e_pc8 load 0.
  - Result: a deterministic nop (add 0,0 → r=0, z=1).
- stall and flush together: behave as a bubble. Neither has priority because the outcome is identical.
- jal: e_rn = RA_IDX regardless of d_rn; e_pc8 = d_pc4 + 4 (mod 2^32, wraps at 0xFFFFFFFC → 0x00000000). EX/MEM selects e_pc8 over the ALU result when e_jal.
- Shamt: only 5 bits are forwarded into alu_a[4:0]; alu_a[31:5] = 0 for shifts. lui uses alu_b = imm, with the ALU doing the shift.
- Reset asserted mid-operation clears the stage immediately, with no wait for clk. Deassertion takes effect at the next edge.
- No X propagation: unknown d_fwd* values are outside the contract.

Decomposition:
- Shared package mips_pkg holds:
  - Forwarding select constants: FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_LOAD=3.
  - ALU opcode constants (ALU_ADD 4'b0000, ALU_SUB 4'b0100, ALU_SLL 4'b0011, ALU_SRA 4'b1111, ALU_LUI 4'b0110, ...).
  - XLEN and RA_IDX.
- One sub-module: fwd_mux4, a 4:1 32-bit forwarding mux instantiated twice (rs, rt). The rest is flat.

Test Plan:
- Reset: drive random inputs, assert rst asynchronously between edges → all outputs 0 immediately; e_aluc=0, e_valid=0.
- Forwarding: d_qa=1, x_alu=2, m_alu=3, m_mdo=4, d_fwda stepped 0..3 on consecutive edges → alu_a = 1, 2, 3, 4 one cycle later. Same check for d_fwdb/e_sdata with d_aluimm=0.
- Immediate and shift:
  - d_shift=1, d_imm=0x00000140, d_qb=0x80000000, d_aluc=ALU_SRA → alu_a=5, alu_b=0x80000000, e_aluc=4'b1111.
  - d_aluimm=1, d_imm=0xFFFF8000, d_fwdb=1 → alu_b=0xFFFF8000, e_sdata=x_alu.
- jal: d_jal=1, d_rn=0, d_pc4=0x00400008 → e_rn=31, e_pc8=0x0040000C, e_wreg=1. With d_pc4=0xFFFFFFFC → e_pc8=0x00000000.
- Bubble: valid sw (d_wmem=1) with stall=1 → e_wmem=0, e_valid=0, alu_a=alu_b=0. Same with flush=1, then both together → identical nop. The next edge with stall=0 captures the instruction normally.
- Back-to-back: three valid adds with fwd selects 1,2,3 on consecutive cycles and no bubbles → each value appears on alu_a exactly one cycle after its capture edge, with no dropped or duplicated cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: datapath width, forwarding selects,
// ALU opcodes and the control bundle carried from ID into EX.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int RA_IDX = 31;

    // Forwarding source selects, driven by the hazard unit.
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EXE  = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_LOAD = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic [3:0] aluc;
        logic [4:0] rn;
    } ex_ctrl_t;

    // A bubble is an add of 0+0 that writes nothing anywhere.
    localparam ex_ctrl_t EX_CTRL_NOP = '{
        valid: 1'b0, wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, jal: 1'b0,
        aluc: ALU_ADD, rn: 5'd0
    };

    function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc4);
        return pc4 + XLEN'(4);
    endfunction

    function automatic logic [XLEN-1:0] shamt_operand(input logic [XLEN-1:0] imm);
        return {{(XLEN-5){1'b0}}, imm[10:6]};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX boundary: decoded instruction and forwarding sources in,
// registered ALU operands and EX/MEM control bundle out.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic            stall;
    logic            flush;

    logic            d_valid;
    logic            d_wreg;
    logic            d_m2reg;
    logic            d_wmem;
    logic            d_jal;
    logic            d_aluimm;
    logic            d_shift;
    logic [3:0]      d_aluc;
    logic [4:0]      d_rn;
    logic [XLEN-1:0] d_pc4;
    logic [XLEN-1:0] d_qa;
    logic [XLEN-1:0] d_qb;
    logic [XLEN-1:0] d_imm;
    logic [1:0]      d_fwda;
    logic [1:0]      d_fwdb;

    logic [XLEN-1:0] x_alu;
    logic [XLEN-1:0] m_alu;
    logic [XLEN-1:0] m_mdo;

    logic            e_valid;
    logic            e_wreg;
    logic            e_m2reg;
    logic            e_wmem;
    logic            e_jal;
    logic [3:0]      e_aluc;
    logic [4:0]      e_rn;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] e_sdata;
    logic [XLEN-1:0] e_pc8;

    // ID/hazard side: produces the instruction, consumes the EX view.
    modport master (
        output stall, flush,
        output d_valid, d_wreg, d_m2reg, d_wmem, d_jal, d_aluimm, d_shift,
        output d_aluc, d_rn, d_pc4, d_qa, d_qb, d_imm, d_fwda, d_fwdb,
        output x_alu, m_alu, m_mdo,
        input  e_valid, e_wreg, e_m2reg, e_wmem, e_jal, e_aluc, e_rn,
        input  alu_a, alu_b, e_sdata, e_pc8
    );

    modport slave (
        input  stall, flush,
        input  d_valid, d_wreg, d_m2reg, d_wmem, d_jal, d_aluimm, d_shift,
        input  d_aluc, d_rn, d_pc4, d_qa, d_qb, d_imm, d_fwda, d_fwdb,
        input  x_alu, m_alu, m_mdo,
        output e_valid, e_wreg, e_m2reg, e_wmem, e_jal, e_aluc, e_rn,
        output alu_a, alu_b, e_sdata, e_pc8
    );

endinterface

// File: rtl/fwd_mux4.sv
// 4:1 operand forwarding mux; select priority is resolved by the hazard unit.
module fwd_mux4
    import mips_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] rf_i,
    input  logic [W-1:0] exe_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] load_i,
    output logic [W-1:0] y_o
);

    // NOTE: default first so every path assigns y_o and no latch is inferred.
    always_comb begin
        y_o = rf_i;
        case (sel_i)
            FWD_RF:   y_o = rf_i;
            FWD_EXE:  y_o = exe_i;
            FWD_MEM:  y_o = mem_i;
            FWD_LOAD: y_o = load_i;
            default:  y_o = rf_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and operand select ahead of the
// flops; stall, flush or an empty ID slot load a deterministic add-0,0 bubble.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN   = mips_pkg::XLEN,
    parameter int RA_IDX = mips_pkg::RA_IDX
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave io
);

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;

    fwd_mux4 #(.W(XLEN)) u_fwd_a (
        .sel_i  (io.d_fwda),
        .rf_i   (io.d_qa),
        .exe_i  (io.x_alu),
        .mem_i  (io.m_alu),
        .load_i (io.m_mdo),
        .y_o    (fa)
    );

    fwd_mux4 #(.W(XLEN)) u_fwd_b (
        .sel_i  (io.d_fwdb),
        .rf_i   (io.d_qb),
        .exe_i  (io.x_alu),
        .mem_i  (io.m_alu),
        .load_i (io.m_mdo),
        .y_o    (fb)
    );

    logic bubble;
    assign bubble = io.stall | io.flush | ~io.d_valid;

    ex_ctrl_t        ctrl_d,  ctrl_q;
    logic [XLEN-1:0] a_d,     a_q;
    logic [XLEN-1:0] b_d,     b_q;
    logic [XLEN-1:0] sdata_d, sdata_q;
    logic [XLEN-1:0] pc8_d,   pc8_q;

    always_comb begin
        ctrl_d  = EX_CTRL_NOP;
        a_d     = '0;
        b_d     = '0;
        sdata_d = '0;
        pc8_d   = '0;
        if (!bubble) begin
            ctrl_d.valid = 1'b1;
            ctrl_d.wreg  = io.d_wreg;
            ctrl_d.m2reg = io.d_m2reg;
            ctrl_d.wmem  = io.d_wmem;
            ctrl_d.jal   = io.d_jal;
            ctrl_d.aluc  = io.d_aluc;
            // jal links into $ra whatever rd field decode produced.
            ctrl_d.rn    = io.d_jal ? 5'(RA_IDX) : io.d_rn;
            a_d          = io.d_shift  ? shamt_operand(io.d_imm) : fa;
            b_d          = io.d_aluimm ? io.d_imm : fb;
            sdata_d      = fb;
            pc8_d        = link_addr(io.d_pc4);
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sdata_q <= '0;
            pc8_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sdata_q <= sdata_d;
            pc8_q   <= pc8_d;
        end
    end

    assign io.e_valid = ctrl_q.valid;
    assign io.e_wreg  = ctrl_q.wreg;
    assign io.e_m2reg = ctrl_q.m2reg;
    assign io.e_wmem  = ctrl_q.wmem;
    assign io.e_jal   = ctrl_q.jal;
    assign io.e_aluc  = ctrl_q.aluc;
    assign io.e_rn    = ctrl_q.rn;
    assign io.alu_a   = a_q;
    assign io.alu_b   = b_q;
    assign io.e_sdata = sdata_q;
    assign io.e_pc8   = pc8_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random traffic
// compared against a one-cycle-delay behavioural model.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if bus ();

    id_ex_stage #(.XLEN(32), .RA_IDX(31)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, wreg, m2reg, wmem, jal;
        logic [3:0]  aluc;
        logic [4:0]  rn;
        logic [31:0] a, b, sdata, pc8;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // What EX should hold after the next edge, from the rules of the stage.
    function automatic exp_t model();
        exp_t        e;
        logic [31:0] src [4];
        logic [31:0] fa, fb;
        e = '{default: '0};
        if (bus.stall || bus.flush || !bus.d_valid) return e;
        src = '{bus.d_qa, bus.x_alu, bus.m_alu, bus.m_mdo};
        fa = src[bus.d_fwda];
        src[0] = bus.d_qb;
        fb = src[bus.d_fwdb];
        e.valid = 1'b1;
        e.wreg  = bus.d_wreg;
        e.m2reg = bus.d_m2reg;
        e.wmem  = bus.d_wmem;
        e.jal   = bus.d_jal;
        e.aluc  = bus.d_aluc;
        e.rn    = bus.d_jal ? 5'd31 : bus.d_rn;
        e.a     = bus.d_shift ? (bus.d_imm >> 6) & 32'h1F : fa;
        e.b     = bus.d_aluimm ? bus.d_imm : fb;
        e.sdata = fb;
        e.pc8   = bus.d_pc4 + 32'd4;
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".e_valid"}, 32'(bus.e_valid), 32'(e.valid));
        check({tag, ".e_wreg"},  32'(bus.e_wreg),  32'(e.wreg));
        check({tag, ".e_m2reg"}, 32'(bus.e_m2reg), 32'(e.m2reg));
        check({tag, ".e_wmem"},  32'(bus.e_wmem),  32'(e.wmem));
        check({tag, ".e_jal"},   32'(bus.e_jal),   32'(e.jal));
        check({tag, ".e_aluc"},  32'(bus.e_aluc),  32'(e.aluc));
        check({tag, ".e_rn"},    32'(bus.e_rn),    32'(e.rn));
        check({tag, ".alu_a"},   bus.alu_a,   e.a);
        check({tag, ".alu_b"},   bus.alu_b,   e.b);
        check({tag, ".e_sdata"}, bus.e_sdata, e.sdata);
        check({tag, ".e_pc8"},   bus.e_pc8,   e.pc8);
    endtask

    task automatic step(input string tag);
        exp_t e;
        e = model();
        @(posedge clk);
        #1;
        check_all(tag, e);
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.flush = 0;
        bus.d_valid = 0; bus.d_wreg = 0; bus.d_m2reg = 0; bus.d_wmem = 0;
        bus.d_jal = 0; bus.d_aluimm = 0; bus.d_shift = 0;
        bus.d_aluc = ALU_ADD; bus.d_rn = 0; bus.d_pc4 = 0;
        bus.d_qa = 0; bus.d_qb = 0; bus.d_imm = 0;
        bus.d_fwda = FWD_RF; bus.d_fwdb = FWD_RF;
        bus.x_alu = 0; bus.m_alu = 0; bus.m_mdo = 0;
    endtask

    task automatic rand_inputs();
        bus.stall    = ($urandom_range(7) == 0);
        bus.flush    = ($urandom_range(7) == 0);
        bus.d_valid  = ($urandom_range(7) != 0);
        bus.d_wreg   = 1'($urandom());
        bus.d_m2reg  = 1'($urandom());
        bus.d_wmem   = 1'($urandom());
        bus.d_jal    = ($urandom_range(5) == 0);
        bus.d_aluimm = 1'($urandom());
        bus.d_shift  = ($urandom_range(3) == 0);
        bus.d_aluc   = 4'($urandom());
        bus.d_rn     = 5'($urandom());
        bus.d_pc4    = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom() & ~32'h3;
        bus.d_qa     = $urandom();
        bus.d_qb     = $urandom();
        bus.d_imm    = $urandom();
        bus.d_fwda   = 2'($urandom());
        bus.d_fwdb   = 2'($urandom());
        bus.x_alu    = $urandom();
        bus.m_alu    = $urandom();
        bus.m_mdo    = $urandom();
    endtask

    exp_t zero_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_exp = '{default: '0};
        clear_inputs();
        rst = 1'b1;
        #12;
        check_all("reset_init", zero_exp);
        rst = 1'b0;

        // Async reset lands mid-cycle and must clear EX before any edge.
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.stall = 0; bus.flush = 0; bus.d_valid = 1;
            step("pre_reset");
        end
        rand_inputs();
        #2 rst = 1'b1;
        #1;
        check_all("reset_async", zero_exp);
        #3 rst = 1'b0;
        clear_inputs();

        // Forwarding sources for rs, then rt with the immediate path off.
        bus.d_valid = 1; bus.d_qa = 1; bus.d_qb = 1;
        bus.x_alu = 2; bus.m_alu = 3; bus.m_mdo = 4;
        for (int s = 0; s < 4; s++) begin
            bus.d_fwda = 2'(s);
            bus.d_fwdb = 2'(s);
            step("fwd");
            check("fwd_a_const", bus.alu_a, 32'(s + 1));
            check("fwd_sdata_const", bus.e_sdata, 32'(s + 1));
            check("fwd_b_const", bus.alu_b, 32'(s + 1));
        end

        // sra by shamt 5: shamt reaches alu_a, rt reaches alu_b.
        clear_inputs();
        bus.d_valid = 1; bus.d_shift = 1; bus.d_imm = 32'h0000_0140;
        bus.d_qb = 32'h8000_0000; bus.d_aluc = ALU_SRA; bus.d_qa = 32'hDEAD_BEEF;
        step("shift");
        check("shift_a", bus.alu_a, 32'd5);
        check("shift_b", bus.alu_b, 32'h8000_0000);
        check("shift_aluc", 32'(bus.e_aluc), 32'hF);

        // Immediate replaces alu_b but store data keeps forwarded rt.
        clear_inputs();
        bus.d_valid = 1; bus.d_aluimm = 1; bus.d_imm = 32'hFFFF_8000;
        bus.d_fwdb = FWD_EXE; bus.x_alu = 32'h1234_5678; bus.d_qb = 32'h5555_AAAA;
        step("imm");
        check("imm_b", bus.alu_b, 32'hFFFF_8000);
        check("imm_sdata", bus.e_sdata, 32'h1234_5678);

        // jal link register and link value, including wrap at top of memory.
        clear_inputs();
        bus.d_valid = 1; bus.d_jal = 1; bus.d_wreg = 1; bus.d_rn = 0;
        bus.d_pc4 = 32'h0040_0008;
        step("jal");
        check("jal_rn", 32'(bus.e_rn), 32'd31);
        check("jal_pc8", bus.e_pc8, 32'h0040_000C);
        check("jal_wreg", 32'(bus.e_wreg), 32'd1);
        bus.d_pc4 = 32'hFFFF_FFFC;
        step("jal_wrap");
        check("jal_wrap_pc8", bus.e_pc8, 32'h0000_0000);

        // A valid sw under stall, flush, and both becomes the same nop.
        clear_inputs();
        bus.d_valid = 1; bus.d_wmem = 1; bus.d_qa = 32'h100; bus.d_qb = 32'h77;
        bus.d_aluimm = 1; bus.d_imm = 32'h8; bus.d_aluc = ALU_ADD; bus.d_pc4 = 32'h40;
        for (int k = 1; k < 4; k++) begin
            bus.stall = k[0];
            bus.flush = k[1];
            step("bubble");
            check_all("bubble_nop", zero_exp);
        end
        bus.stall = 0; bus.flush = 0;
        step("after_stall");
        check("after_stall_wmem", 32'(bus.e_wmem), 32'd1);
        check("after_stall_b", bus.alu_b, 32'h8);

        // Back-to-back adds: each forwarded value shows exactly one cycle later.
        clear_inputs();
        bus.d_valid = 1;
        for (int k = 1; k < 4; k++) begin
            bus.d_fwda = 2'(k);
            bus.x_alu = 32'h1000 + 32'(k);
            bus.m_alu = 32'h2000 + 32'(k);
            bus.m_mdo = 32'h3000 + 32'(k);
            step("b2b");
            check("b2b_a", bus.alu_a, 32'(k * 32'h1000 + k));
        end

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
